// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and sizing for the 4-way round-robin arbiter.
// The hold limit stays a parameter of the arbiter itself.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_t;

  // Result of a cyclic priority scan: found is low when no request is pending.
  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

endpackage

// File: rtl/decoder_2x4.sv
// Plain 2-to-4 one-hot decoder.
module decoder_2x4 (
  input  logic [1:0] A,
  output logic [3:0] D
);

  always_comb begin
    D    = 4'b0000;
    D[A] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time under contention.
// All outputs come from registered state; req never reaches gnt combinationally.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  // Handshake: gnt/gnt_idx/gnt_valid describe the owner for the whole cycle;
  // a requester keeps req high while it wants the resource and drops it to release.
  state_t     state;
  idx_t       ptr;
  logic [3:0] hold_cnt;
  idx_t       owner;

  req_t  owner_onehot;
  req_t  others;
  logic  owner_req;
  idx_t  rot_ptr;
  pick_t pick_idle;
  pick_t pick_handoff;

  // Scan start, start+1, ... (mod 4); the reverse loop lets the closest hit win.
  function automatic pick_t pick_winner(input req_t r, input idx_t start);
    pick_t p;
    idx_t  j;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = start + idx_t'(k);
      if (r[j]) begin
        p.found = 1'b1;
        p.idx   = j;
      end
    end
    return p;
  endfunction

  decoder_2x4 u_dec (
    .A (owner),
    .D (owner_onehot)
  );

  always_comb begin
    owner_req    = |(req & owner_onehot);
    others       = req & ~owner_onehot;
    rot_ptr      = owner + 2'd1;
    pick_idle    = pick_winner(req, ptr);
    // On release the owner bit is already low, so one masked scan serves both handoffs.
    pick_handoff = pick_winner(others, rot_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      owner    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle.found) begin
            state    <= GRANT;
            owner    <= pick_idle.idx;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            ptr      <= rot_ptr;
            hold_cnt <= '0;
            if (pick_handoff.found) begin
              owner <= pick_handoff.idx;
            end else begin
              state <= IDLE;
            end
          end else if ((|others) && (hold_cnt == HOLD_LAST)) begin
            ptr      <= rot_ptr;
            owner    <= pick_handoff.idx;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= (hold_cnt == HOLD_LAST) ? 4'd0 : hold_cnt + 4'd1;
          end
        end
      endcase
    end
  end

  assign gnt_idx   = owner;
  assign gnt_valid = (state == GRANT);
  assign gnt       = owner_onehot & {4{gnt_valid}};

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: vector table, hand-written corner
// sequences and a randomized phase against a small behavioral model.
module tb_rr_arbiter_4;

  localparam int MAX_HOLD = 4;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       chk_idx;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pack_exp(input logic c, input logic v,
                                            input logic [1:0] i, input logic [3:0] g);
    return {c, v, i, g};
  endfunction

  function automatic void add_vec(input logic r, input logic [3:0] q, input logic [3:0] g,
                                  input logic [1:0] i, input logic v, input logic c);
    vec_t e;
    e.rst = r; e.req = q; e.gnt = g; e.idx = i; e.valid = v; e.chk_idx = c;
    vecs.push_back(e);
  endfunction

  // scoreboard compare: pops one expected record and checks the live outputs
  task automatic check_out(input string name);
    logic [W-1:0] e;
    logic         bad;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      bad = (gnt_valid !== e[6]) || (gnt !== e[3:0]) || (e[7] && (gnt_idx !== e[5:4]));
      if (bad) begin
        errors++;
        $display("FAIL %s: got gnt=%b idx=%0d valid=%b, want gnt=%b idx=%0d valid=%b",
                 name, gnt, gnt_idx, gnt_valid, e[3:0], e[5:4], e[6]);
      end
    end
  endtask

  // driver: inputs change on the falling edge, outputs compared one edge later
  task automatic step(input logic r, input logic [3:0] q, input logic [W-1:0] e,
                      input string name);
    rst = r;
    req = q;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_out(name);
  endtask

  task automatic check_ptr(input logic [1:0] want, input string name);
    checks++;
    if (dut.ptr !== want) begin
      errors++;
      $display("FAIL %s: got ptr=%0d, want ptr=%0d", name, dut.ptr, want);
    end
  endtask

  // behavioral model for the randomized phase
  logic       m_grant;
  int         m_ptr, m_hold, m_idx;

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++) begin
      if (r[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic r, input logic [3:0] q);
    logic [3:0] rest;
    int         w;
    if (r) begin
      m_grant = 1'b0; m_ptr = 0; m_hold = 0; m_idx = 0;
    end else if (!m_grant) begin
      if (q != 4'b0000) begin
        m_grant = 1'b1; m_idx = first_from(q, m_ptr); m_hold = 0;
      end
    end else begin
      rest = q;
      rest[m_idx] = 1'b0;
      if (!q[m_idx]) begin
        m_ptr = (m_idx + 1) % 4;
        w = first_from(q, m_ptr);
        m_hold = 0;
        if (w < 0) m_grant = 1'b0;
        else m_idx = w;
      end else if (rest != 4'b0000 && m_hold == MAX_HOLD - 1) begin
        m_ptr = (m_idx + 1) % 4;
        m_idx = first_from(rest, m_ptr);
        m_hold = 0;
      end else begin
        m_hold = (m_hold == MAX_HOLD - 1) ? 0 : m_hold + 1;
      end
    end
  endfunction

  initial begin
    logic [3:0] g;
    logic       r;
    logic [3:0] q;

    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);

    // reset held with every requester asking
    for (int k = 0; k < 3; k++) add_vec(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    // single requester: 1-cycle latency, long hold, release to idle
    add_vec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) add_vec(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1);
    add_vec(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    // full contention: 0,1,2,3,0 each for MAX_HOLD cycles
    add_vec(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < MAX_HOLD; c++) begin
        g = 4'(1 << o);
        add_vec(1'b0, 4'b1111, g, 2'(o), 1'b1, 1'b1);
      end
    end
    add_vec(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    // reset pulse while requester 2 owns the grant
    add_vec(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) add_vec(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) add_vec(1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) add_vec(1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b1);
    add_vec(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1);
    add_vec(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b1);

    foreach (vecs[n]) begin
      step(vecs[n].rst, vecs[n].req,
           pack_exp(vecs[n].chk_idx, vecs[n].valid, vecs[n].idx, vecs[n].gnt),
           $sformatf("vec%0d", n));
    end

    // early release: 0 drops after 2 cycles, scan from 1 finds 3
    step(1'b1, 4'b0000, pack_exp(1'b1, 1'b0, 2'd0, 4'b0000), "er_rst");
    step(1'b0, 4'b1001, pack_exp(1'b1, 1'b1, 2'd0, 4'b0001), "er_g0a");
    step(1'b0, 4'b1001, pack_exp(1'b1, 1'b1, 2'd0, 4'b0001), "er_g0b");
    step(1'b0, 4'b1000, pack_exp(1'b1, 1'b1, 2'd3, 4'b1000), "er_g3");
    check_ptr(2'd1, "er_ptr");

    // wrap-around: owner 3 times out, scan 0,1 lands on 1
    step(1'b1, 4'b0000, pack_exp(1'b1, 1'b0, 2'd0, 4'b0000), "wr_rst");
    step(1'b0, 4'b1000, pack_exp(1'b1, 1'b1, 2'd3, 4'b1000), "wr_g3");
    for (int k = 0; k < MAX_HOLD - 1; k++)
      step(1'b0, 4'b1010, pack_exp(1'b1, 1'b1, 2'd3, 4'b1000), $sformatf("wr_hold%0d", k));
    step(1'b0, 4'b1010, pack_exp(1'b1, 1'b1, 2'd1, 4'b0010), "wr_g1");
    check_ptr(2'd0, "wr_ptr");

    // randomized traffic against the model
    model_step(1'b1, 4'b0000);
    step(1'b1, 4'b0000, pack_exp(1'b1, 1'b0, 2'd0, 4'b0000), "rnd_rst");
    q = 4'b0000;
    for (int n = 0; n < 300; n++) begin
      r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) != 0) q = 4'($urandom_range(0, 15));
      model_step(r, q);
      g = m_grant ? 4'(1 << m_idx) : 4'b0000;
      step(r, q, pack_exp(m_grant, m_grant, 2'(m_idx), g), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum consecutive grant cycles an owner holds while another requester waits; legal range 1..15.
REQ-002 Port clk  input  1  the single clock; all state updates SHALL occur on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous and active-high.
REQ-004 Port req  input  4  request lines; req[i] high means requester i wants the shared resource.
REQ-005 Port gnt  output  4  one-hot grant; gnt[i] high means requester i owns the resource.
REQ-006 Port gnt_idx  output  2  binary index of the current owner.
REQ-007 Port gnt_valid  output  1  high when some requester holds a grant.

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE (no owner) and GRANT (owner = gnt_idx).
REQ-009 The block SHALL keep a 2-bit priority pointer ptr and a 4-bit hold counter hold_cnt.
REQ-010 Winner selection SHALL pick the first i with req[i]=1, scanning cyclically ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-011 IDLE: if req!=0, the next state SHALL be GRANT with gnt_idx=winner, hold_cnt=0; otherwise the FSM SHALL remain in IDLE; latency from req sampled high to gnt high is exactly 1 cycle.
REQ-012 GRANT, owner release: if req[gnt_idx]=0, ptr SHALL become gnt_idx+1 (mod 4), and the next state SHALL be GRANT to the winner computed from the new ptr (no idle bubble), or IDLE if no other request is pending.
REQ-013 GRANT, timeout: if req[gnt_idx]=1, hold_cnt=MAX_HOLD-1 and any other req bit is high, ptr SHALL become gnt_idx+1 (mod 4) and the grant SHALL move to the winner excluding the current owner, with hold_cnt=0.
REQ-014 GRANT, no contention: if req[gnt_idx]=1 and no other req bit is high, the grant SHALL persist; hold_cnt SHALL increment and wrap from MAX_HOLD-1 to 0.
REQ-015 GRANT, otherwise: the grant SHALL persist and hold_cnt SHALL increment by 1.
REQ-016 Under continuous contention each owner SHALL hold the grant exactly MAX_HOLD consecutive cycles.
REQ-017 Pointer wrap SHALL be modulo 4 (3+1=0).
REQ-018 gnt SHALL equal the 2-to-4 decode of gnt_idx when gnt_valid=1, and SHALL be 4'b0000 when gnt_valid=0; at most one gnt bit SHALL be high in any cycle.
REQ-019 gnt_valid SHALL be 1 exactly when the FSM is in GRANT.
REQ-020 All outputs SHALL be registered or derived only from registered state (no combinational path from req to gnt).

Reset
REQ-021 While rst=1 at a clock edge, the next state SHALL be IDLE, with ptr=0, hold_cnt=0, gnt_idx=2'b00, gnt_valid=0 and gnt=4'b0000.
REQ-022 rst SHALL take priority over all FSM transitions, including mid-grant; gnt SHALL be 4'b0000 in the cycle following the edge at which rst is sampled high.
REQ-023 After rst deasserts, arbitration SHALL restart with requester 0 at highest priority.

Structure
REQ-024 The 2-to-4 decode of gnt_idx SHALL be an instance of the existing decoder_2x4 module (ports A, D), gated by gnt_valid.
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE=1'b0, GRANT=1'b1), requester count (4) and index width (2); MAX_HOLD remains a module parameter.
REQ-026 The winner-selection logic SHALL be a function inside rr_arbiter_4, not a separate module.

Verification
REQ-027 Reset: assert rst with req=4'b1111 -> gnt=4'b0000, gnt_valid=0 and gnt_idx=0 on every cycle while rst is high.
REQ-028 Single requester: req=4'b0100 from IDLE -> one cycle later gnt=4'b0100, gnt_idx=2; hold req for 10 cycles -> the grant never drops; drop req -> gnt=4'b0000 on the next cycle.
REQ-029 Full contention: MAX_HOLD=4, req=4'b1111 after reset -> the grant sequence is 0,1,2,3,0, each index held exactly 4 cycles, with no idle cycle between owners.
REQ-030 Early release: req=4'b1001, requester 0 granted and drops req after 2 cycles -> the next cycle gives gnt=4'b1000; ptr then equals 1.
REQ-031 Wrap-around: owner 3 times out while req=4'b1010 -> the grant goes to 1 (scan 0,1).
REQ-032 Mid-grant reset: rst pulsed for 1 cycle during requester 2's grant with req=4'b1111 -> gnt=0 in the following cycle, then requester 0 is granted one cycle after rst deasserts.
